// File: rtl/tnn_tree_pkg.sv
//==============================================================================
// Module  : tnn_tree_pkg
// Brief   : Shared widths, node-table entry layout and walker state encoding
//           for the decision-tree walker.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package tnn_tree_pkg;

    localparam int NUM_FEAT   = 11;
    localparam int FEAT_W     = 3;
    localparam int NUM_NODES  = 32;
    localparam int CLASS_W    = 3;
    localparam int MAX_DEPTH  = 8;

    localparam int NODE_IDX_W = $clog2(NUM_NODES);
    localparam int FEAT_IDX_W = $clog2(NUM_FEAT);
    localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1);

    // leaf_class carries the node's class ("class" is a reserved word)
    typedef struct packed {
        logic                  leaf;
        logic [FEAT_IDX_W-1:0] feat_idx;
        logic [FEAT_W-1:0]     thresh;
        logic [NODE_IDX_W-1:0] left;
        logic [NODE_IDX_W-1:0] right;
        logic [CLASS_W-1:0]    leaf_class;
    } node_t;

    localparam int NODE_W = $bits(node_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tnn_cmp_gt.sv
//==============================================================================
// Module  : tnn_cmp_gt
// Brief   : Exact unsigned "a > b" comparator node; an approximate library
//           variant with the same ports may replace it.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tnn_cmp_gt
    import tnn_tree_pkg::*;
(
    input  logic [FEAT_W-1:0] a,
    input  logic [FEAT_W-1:0] b,
    output logic              gt
);

    assign gt = (a > b);

endmodule

`default_nettype wire

// File: rtl/tnn_tree_walker.sv
//==============================================================================
// Module  : tnn_tree_walker
// Brief   : Walks one decision tree per feature vector with a single shared
//           comparator, one node per cycle, from root 0 to a leaf.
//           Optional statistics counters: define TNN_TREE_STATS_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tnn_tree_walker
    import tnn_tree_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [NODE_IDX_W-1:0]      cfg_addr,
    input  logic [NODE_W-1:0]          cfg_wdata,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_FEAT*FEAT_W-1:0] in_feat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CLASS_W-1:0]         out_class,
    output logic                       out_err,
    output logic                       busy
`ifdef TNN_TREE_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [15:0]                stat_cmp_cnt,
    output logic [15:0]                stat_inf_cnt
`endif
);

    localparam node_t c_reset_node = '{leaf: 1'b1, default: '0};

    state_t                      r_state;
    node_t                       r_table [NUM_NODES];
    logic [NUM_FEAT*FEAT_W-1:0]  r_feat;
    logic [NODE_IDX_W-1:0]       r_node_ptr;
    logic [DEPTH_W-1:0]          r_depth;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic [CLASS_W-1:0]          r_out_class;
    logic                        r_out_err;
    logic                        r_busy;

    node_t                       w_node;
    logic [FEAT_W-1:0]           w_feat;
    logic                        w_gt;
    logic                        w_at_limit;

    assign w_node     = r_table[r_node_ptr];
    assign w_at_limit = (r_depth == DEPTH_W'(MAX_DEPTH));

    // Out-of-range feature indices read as zero
    always_comb begin
        w_feat = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            if (w_node.feat_idx == FEAT_IDX_W'(k)) begin
                w_feat = r_feat[k*FEAT_W +: FEAT_W];
            end
        end
    end

    tnn_cmp_gt u_cmp (
        .a  (w_feat),
        .b  (w_node.thresh),
        .gt (w_gt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_feat      <= '0;
            r_node_ptr  <= '0;
            r_depth     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_err   <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < NUM_NODES; i++) begin
                r_table[i] <= c_reset_node;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    // Table writes only land while idle so a walk never sees a torn tree
                    if (cfg_we) begin
                        r_table[cfg_addr] <= node_t'(cfg_wdata);
                    end
                    if (in_valid) begin
                        r_feat     <= in_feat;
                        r_node_ptr <= '0;
                        r_depth    <= '0;
                        r_state    <= WALK;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                WALK: begin
                    if (w_node.leaf) begin
                        r_out_class <= w_node.leaf_class;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_at_limit) begin
                        r_out_class <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_node_ptr <= w_gt ? w_node.right : w_node.left;
                        r_depth    <= r_depth + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign out_err   = r_out_err;
    assign busy      = r_busy;

`ifdef TNN_TREE_STATS_EN
    logic [15:0] r_cmp_cnt;
    logic [15:0] r_inf_cnt;
    logic        w_cmp_evt;
    logic        w_inf_evt;

    assign w_cmp_evt = (r_state == WALK) && !w_node.leaf && !w_at_limit;
    assign w_inf_evt = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            r_cmp_cnt <= '0;
            r_inf_cnt <= '0;
        end else begin
            if (w_cmp_evt && (r_cmp_cnt != 16'hFFFF)) begin
                r_cmp_cnt <= r_cmp_cnt + 16'd1;
            end
            if (w_inf_evt && (r_inf_cnt != 16'hFFFF)) begin
                r_inf_cnt <= r_inf_cnt + 16'd1;
            end
        end
    end

    assign stat_cmp_cnt = r_cmp_cnt;
    assign stat_inf_cnt = r_inf_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tnn_tree_walker.sv
//==============================================================================
// Module  : tb_tnn_tree_walker
// Brief   : Directed self-checking bench for tnn_tree_walker.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tnn_tree_walker;
    import tnn_tree_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       cfg_we;
    logic [NODE_IDX_W-1:0]      cfg_addr;
    logic [NODE_W-1:0]          cfg_wdata;
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_FEAT*FEAT_W-1:0] in_feat;
    logic                       out_valid;
    logic                       out_ready;
    logic [CLASS_W-1:0]         out_class;
    logic                       out_err;
    logic                       busy;

    int checks = 0;
    int errors = 0;

    tnn_tree_walker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All features set to fill, except feature 2
    function automatic logic [NUM_FEAT*FEAT_W-1:0] feat_vec(input int f2, input int fill);
        logic [NUM_FEAT*FEAT_W-1:0] v;
        for (int k = 0; k < NUM_FEAT; k++) v[k*FEAT_W +: FEAT_W] = FEAT_W'(fill);
        v[2*FEAT_W +: FEAT_W] = FEAT_W'(f2);
        return v;
    endfunction

    function automatic logic [NODE_W-1:0] mk_node(input bit leaf, input int fi, input int th,
                                                  input int l, input int r, input int cls);
        node_t n;
        n.leaf       = leaf;
        n.feat_idx   = FEAT_IDX_W'(fi);
        n.thresh     = FEAT_W'(th);
        n.left       = NODE_IDX_W'(l);
        n.right      = NODE_IDX_W'(r);
        n.leaf_class = CLASS_W'(cls);
        return n;
    endfunction

    task automatic write_node(input int addr, input logic [NODE_W-1:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = NODE_IDX_W'(addr);
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic program_tree();
        write_node(0, mk_node(1'b0, 2, 3, 1, 2, 0));
        write_node(1, mk_node(1'b1, 0, 0, 0, 0, 5));
        write_node(2, mk_node(1'b1, 0, 0, 0, 0, 6));
    endtask

    // Accept one vector and count edges until out_valid is seen
    task automatic start_walk(input logic [NUM_FEAT*FEAT_W-1:0] f, output int lat);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_before_accept got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        in_feat  = f;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat >= 40) begin
            errors++;
            $display("FAIL walk_timeout got no out_valid after %0d edges want <=9", lat);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks += 5;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_class !== 3'd0) begin errors++; $display("FAIL reset_out_class got %0d want 0", out_class); end
        if (out_err !== 1'b0)   begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int lat;
        program_tree();
        start_walk(feat_vec(4, 0), lat);
        checks += 5;
        if (out_class !== 3'd6) begin errors++; $display("FAIL basic_class got %0d want 6", out_class); end
        if (out_err !== 1'b0)   begin errors++; $display("FAIL basic_err got %b want 0", out_err); end
        if (lat !== 2)          begin errors++; $display("FAIL basic_latency got %0d want 2", lat); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL basic_busy_done got %b want 1", busy); end
        consume();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", out_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL basic_busy_idle got %b want 0", busy); end
    endtask

    task automatic test_equal();
        int lat;
        start_walk(feat_vec(3, 7), lat);
        checks++;
        if (out_class !== 3'd5) begin errors++; $display("FAIL equal_class got %0d want 5", out_class); end
        consume();
        start_walk(feat_vec(0, 7), lat);
        checks++;
        if (out_class !== 3'd5) begin errors++; $display("FAIL zero_class got %0d want 5", out_class); end
        consume();
        start_walk(feat_vec(7, 0), lat);
        checks++;
        if (out_class !== 3'd6) begin errors++; $display("FAIL max_class got %0d want 6", out_class); end
        consume();
        // Feature index 12 is out of range, so it reads 0 and goes left
        write_node(0, mk_node(1'b0, 12, 0, 1, 2, 0));
        start_walk(feat_vec(7, 7), lat);
        checks++;
        if (out_class !== 3'd5) begin errors++; $display("FAIL oob_feat_class got %0d want 5", out_class); end
        consume();
        program_tree();
    endtask

    task automatic test_depth_limit();
        int lat;
        write_node(0, mk_node(1'b0, 2, 3, 0, 0, 0));
        start_walk(feat_vec(4, 0), lat);
        checks += 3;
        if (out_err !== 1'b1)   begin errors++; $display("FAIL depth_err got %b want 1", out_err); end
        if (out_class !== 3'd0) begin errors++; $display("FAIL depth_class got %0d want 0", out_class); end
        if (lat !== 9)          begin errors++; $display("FAIL depth_latency got %0d want 9", lat); end
        consume();
        program_tree();
    endtask

    task automatic test_backpressure();
        int lat;
        start_walk(feat_vec(4, 0), lat);
        in_valid = 1'b1;
        in_feat  = feat_vec(0, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b want 1", c, out_valid); end
            if (out_class !== 3'd6) begin errors++; $display("FAIL bp_class cycle %0d got %0d want 6", c, out_class); end
            if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready); end
        end
        in_valid = 1'b0;
        consume();
        checks += 3;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_ready_after got %b want 1", in_ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL bp_busy_after got %b want 0", busy); end
        if (out_class !== 3'd6) begin errors++; $display("FAIL bp_class_hold got %0d want 6", out_class); end
        start_walk(feat_vec(0, 0), lat);
        checks++;
        if (out_class !== 3'd5) begin errors++; $display("FAIL bp_second_class got %0d want 5", out_class); end
        consume();
    endtask

    task automatic test_cfg_midwalk();
        int lat;
        in_valid = 1'b1;
        in_feat  = feat_vec(4, 0);
        tick();
        in_valid = 1'b0;
        write_node(2, mk_node(1'b1, 0, 0, 0, 0, 7));
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks += 2;
        if (out_class !== 3'd6) begin errors++; $display("FAIL cfg_midwalk_class got %0d want 6", out_class); end
        if (lat !== 2)          begin errors++; $display("FAIL cfg_midwalk_latency got %0d want 2", lat); end
        consume();
        // Same-cycle write and accept in IDLE: the walk must see the new entry
        cfg_we    = 1'b1;
        cfg_addr  = NODE_IDX_W'(2);
        cfg_wdata = mk_node(1'b1, 0, 0, 0, 0, 7);
        start_walk(feat_vec(4, 0), lat);
        cfg_we    = 1'b0;
        checks++;
        if (out_class !== 3'd7) begin errors++; $display("FAIL cfg_idle_class got %0d want 7", out_class); end
        consume();
        program_tree();
    endtask

    task automatic test_reset_midwalk();
        int lat;
        write_node(0, mk_node(1'b0, 2, 3, 0, 0, 0));
        in_valid = 1'b1;
        in_feat  = feat_vec(4, 0);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstwalk_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstwalk_in_ready got %b want 1", in_ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rstwalk_busy got %b want 0", busy); end
        // Table is back to all-leaf class 0: root answers immediately
        start_walk(feat_vec(4, 0), lat);
        checks += 3;
        if (out_class !== 3'd0) begin errors++; $display("FAIL rst_table_class got %0d want 0", out_class); end
        if (out_err !== 1'b0)   begin errors++; $display("FAIL rst_table_err got %b want 0", out_err); end
        if (lat !== 1)          begin errors++; $display("FAIL rst_table_latency got %0d want 1", lat); end
        consume();
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        in_valid  = 1'b0;
        in_feat   = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_equal();
        test_depth_limit();
        test_backpressure();
        test_cfg_midwalk();
        test_reset_midwalk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
